// File: rtl/tpg_pkg.sv
// Shared definitions for the multi-pattern test pattern generator.
package tpg_pkg;

    localparam int unsigned MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_GRID    = 3'd0;
    localparam mode_t MODE_BARS    = 3'd1;
    localparam mode_t MODE_CHECKER = 3'd2;
    localparam mode_t MODE_RAMP    = 3'd3;
    localparam mode_t MODE_SOLID   = 3'd4;

endpackage

// File: rtl/tpg_multi_if.sv
// Beam timing in, pattern pixels out; master drives timing and controls, slave is the generator.
interface tpg_multi_if #(
    parameter int unsigned COLOR_BITS = 1,
    parameter int unsigned HPOS_W     = 9,
    parameter int unsigned VPOS_W     = 9,
    parameter int unsigned FRAME_W    = 8
);
    import tpg_pkg::*;

    logic                    hsync_i;
    logic                    vsync_i;
    logic                    display_on_i;
    logic [HPOS_W-1:0]       hpos;
    logic [VPOS_W-1:0]       vpos;
    mode_t                   mode_sel;
    logic [3*COLOR_BITS-1:0] solid_rgb;
    logic                    scroll_en;
    logic [3:0]              scroll_step;

    logic                    hsync;
    logic                    vsync;
    logic                    display_on;
    logic [3*COLOR_BITS-1:0] rgb;
    logic [FRAME_W-1:0]      frame_count;

    modport master (
        output hsync_i, vsync_i, display_on_i, hpos, vpos,
               mode_sel, solid_rgb, scroll_en, scroll_step,
        input  hsync, vsync, display_on, rgb, frame_count
    );

    modport slave (
        input  hsync_i, vsync_i, display_on_i, hpos, vpos,
               mode_sel, solid_rgb, scroll_en, scroll_step,
        output hsync, vsync, display_on, rgb, frame_count
    );

endinterface

// File: rtl/tpg_frame_ctl.sv
// Frame-edge detection, frame counter and per-frame latching of pattern controls.
// Horizontal scrolling is built only when TPG_SCROLL_EN is defined.
module tpg_frame_ctl
    import tpg_pkg::*;
#(
    parameter int unsigned COLOR_BITS = 1,
    parameter int unsigned HPOS_W     = 9,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_vsync,
    input  mode_t                   i_mode_sel,
    input  logic [3*COLOR_BITS-1:0] i_solid_rgb,
    input  logic                    i_scroll_en,
    input  logic [3:0]              i_scroll_step,
    output logic [FRAME_W-1:0]      o_frame_count,
    output mode_t                   o_mode,
    output logic [3*COLOR_BITS-1:0] o_solid_rgb,
    output logic                    o_scroll_en,
    output logic [HPOS_W-1:0]       o_scroll_x
);

    logic                    r_vsync_q;
    logic [FRAME_W-1:0]      r_frame_count;
    mode_t                   r_mode;
    logic [3*COLOR_BITS-1:0] r_solid_rgb;
    logic                    w_frame_edge;

    assign w_frame_edge = i_vsync & ~r_vsync_q;

    // Controls only take effect at a frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vsync_q     <= 1'b0;
            r_frame_count <= '0;
            r_mode        <= MODE_GRID;
            r_solid_rgb   <= '0;
        end else begin
            r_vsync_q <= i_vsync;
            if (w_frame_edge) begin
                r_frame_count <= r_frame_count + FRAME_W'(1);
                r_mode        <= i_mode_sel;
                r_solid_rgb   <= i_solid_rgb;
            end
        end
    end

`ifdef TPG_SCROLL_EN
    logic              r_scroll_en;
    logic [HPOS_W-1:0] r_scroll_x;

    // Offset advances using the enable being latched at this same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scroll_en <= 1'b0;
            r_scroll_x  <= '0;
        end else if (w_frame_edge) begin
            r_scroll_en <= i_scroll_en;
            if (i_scroll_en) begin
                r_scroll_x <= r_scroll_x + HPOS_W'(i_scroll_step);
            end
        end
    end

    assign o_scroll_en = r_scroll_en;
    assign o_scroll_x  = r_scroll_x;
`else
    logic w_unused_scroll;

    assign w_unused_scroll = ^{i_scroll_en, i_scroll_step};
    assign o_scroll_en     = 1'b0;
    assign o_scroll_x      = '0;
`endif

    assign o_frame_count = r_frame_count;
    assign o_mode        = r_mode;
    assign o_solid_rgb   = r_solid_rgb;

endmodule

// File: rtl/tpg_multi.sv
// Multi-mode video test pattern generator: pattern mux plus one-cycle aligned outputs.
// Optional horizontal scroll (in tpg_frame_ctl) is enabled by defining TPG_SCROLL_EN.
module tpg_multi
    import tpg_pkg::*;
#(
    parameter int unsigned COLOR_BITS = 1,
    parameter int unsigned HPOS_W     = 9,
    parameter int unsigned VPOS_W     = 9,
    parameter int unsigned CELL_LOG2  = 3,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    tpg_multi_if.slave  bus
);

    localparam logic [COLOR_BITS-1:0] ONES = {COLOR_BITS{1'b1}};

    logic [FRAME_W-1:0]      w_frame_count;
    mode_t                   w_mode;
    logic [3*COLOR_BITS-1:0] w_solid_rgb;
    logic                    w_scroll_en;
    logic [HPOS_W-1:0]       w_scroll_x;
    logic [HPOS_W-1:0]       w_x;
    logic [VPOS_W-1:0]       w_y;
    logic [COLOR_BITS-1:0]   w_r;
    logic [COLOR_BITS-1:0]   w_g;
    logic [COLOR_BITS-1:0]   w_b;
    logic                    w_unused_xy;

    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_display_on;
    logic [3*COLOR_BITS-1:0] r_rgb;

    tpg_frame_ctl #(
        .COLOR_BITS (COLOR_BITS),
        .HPOS_W     (HPOS_W),
        .FRAME_W    (FRAME_W)
    ) u_frame_ctl (
        .clk           (clk),
        .reset         (reset),
        .i_vsync       (bus.vsync_i),
        .i_mode_sel    (bus.mode_sel),
        .i_solid_rgb   (bus.solid_rgb),
        .i_scroll_en   (bus.scroll_en),
        .i_scroll_step (bus.scroll_step),
        .o_frame_count (w_frame_count),
        .o_mode        (w_mode),
        .o_solid_rgb   (w_solid_rgb),
        .o_scroll_en   (w_scroll_en),
        .o_scroll_x    (w_scroll_x)
    );

    assign w_x = w_scroll_en ? HPOS_W'(bus.hpos + w_scroll_x) : bus.hpos;
    assign w_y = bus.vpos;

    // Not every coordinate or counter bit feeds a pattern.
    assign w_unused_xy = ^{w_x, w_y, w_frame_count};

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (w_mode)
            MODE_GRID: begin
                if ((w_x[CELL_LOG2-1:0] == '0) || (w_y[CELL_LOG2-1:0] == '0)) w_r = ONES;
                if (w_y[CELL_LOG2+1]) w_g = ONES;
                if (w_x[CELL_LOG2+1]) w_b = ONES;
            end
            MODE_BARS: begin
                w_r = {COLOR_BITS{w_x[HPOS_W-3]}};
                w_g = {COLOR_BITS{w_x[HPOS_W-2]}};
                w_b = {COLOR_BITS{w_x[HPOS_W-1]}};
            end
            MODE_CHECKER: begin
                if (w_x[CELL_LOG2] ^ w_y[CELL_LOG2]) begin
                    w_r = ONES;
                    w_g = ONES;
                    w_b = ONES;
                end
            end
            MODE_RAMP: begin
                w_r = w_x[HPOS_W-1 -: COLOR_BITS];
                w_g = w_y[VPOS_W-1 -: COLOR_BITS];
                w_b = w_frame_count[COLOR_BITS-1:0];
            end
            MODE_SOLID: begin
                {w_b, w_g, w_r} = w_solid_rgb;
            end
            default: begin
                w_r = '0;
                w_g = '0;
                w_b = '0;
            end
        endcase
        if (!bus.display_on_i) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    // Timing and pixel share one register stage so they stay aligned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_display_on <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_hsync      <= bus.hsync_i;
            r_vsync      <= bus.vsync_i;
            r_display_on <= bus.display_on_i;
            r_rgb        <= {w_b, w_g, w_r};
        end
    end

    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.display_on  = r_display_on;
    assign bus.rgb         = r_rgb;
    assign bus.frame_count = w_frame_count;

endmodule

// File: tb/tb_tpg_multi.sv
// Table-driven scoreboard bench for tpg_multi at default parameters.
module tb_tpg_multi;
    import tpg_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tpg_multi_if bus ();

    tpg_multi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic       hs;
        logic       vs;
        logic       de;
        logic [8:0] hpos;
        logic [8:0] vpos;
        logic [2:0] mode;
        logic [2:0] solid;
        logic       sen;
        logic [3:0] step;
        logic [2:0] rgb;
    } vec_t;

    typedef struct {
        string      name;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] fc;
    } exp_t;

`ifdef TPG_SCROLL_EN
    localparam logic [2:0] EXP_SCR_500 = 3'b000;
    localparam logic [2:0] EXP_SCR_308 = 3'b101;
`else
    localparam logic [2:0] EXP_SCR_500 = 3'b111;
    localparam logic [2:0] EXP_SCR_308 = 3'b100;
`endif

    vec_t       vecs[$];
    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic       m_vsq = 1'b0;
    logic [7:0] m_fc = 8'd0;

    task automatic add(input string name, input int rst_n, input int hs, input int vs,
                       input int de, input int hpos, input int vpos, input int mode,
                       input int solid, input int sen, input int step, input int rgb);
        vec_t v;
        v.name  = name;
        v.rst_n = 1'(rst_n);
        v.hs    = 1'(hs);
        v.vs    = 1'(vs);
        v.de    = 1'(de);
        v.hpos  = 9'(hpos);
        v.vpos  = 9'(vpos);
        v.mode  = 3'(mode);
        v.solid = 3'(solid);
        v.sen   = 1'(sen);
        v.step  = 4'(step);
        v.rgb   = 3'(rgb);
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset            = v.rst_n;
        bus.hsync_i      = v.hs;
        bus.vsync_i      = v.vs;
        bus.display_on_i = v.de;
        bus.hpos         = v.hpos;
        bus.vpos         = v.vpos;
        bus.mode_sel     = v.mode;
        bus.solid_rgb    = v.solid;
        bus.scroll_en    = v.sen;
        bus.scroll_step  = v.step;
        if (!v.rst_n) begin
            m_fc  = 8'd0;
            m_vsq = 1'b0;
        end else begin
            if (v.vs && !m_vsq) m_fc = m_fc + 8'd1;
            m_vsq = v.vs;
        end
        e.name = v.name;
        e.rgb  = v.rgb;
        e.hs   = v.rst_n & v.hs;
        e.vs   = v.rst_n & v.vs;
        e.de   = v.rst_n & v.de;
        e.fc   = m_fc;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", name, field, act, req);
        end
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.name, "rgb",         int'(bus.rgb),         int'(e.rgb));
            chk(e.name, "hsync",       int'(bus.hsync),       int'(e.hs));
            chk(e.name, "vsync",       int'(bus.vsync),       int'(e.vs));
            chk(e.name, "display_on",  int'(bus.display_on),  int'(e.de));
            chk(e.name, "frame_count", int'(bus.frame_count), int'(e.fc));
        end
    end

    initial begin
        vec_t v;
        reset            = 1'b0;
        bus.hsync_i      = 1'b0;
        bus.vsync_i      = 1'b0;
        bus.display_on_i = 1'b0;
        bus.hpos         = '0;
        bus.vpos         = '0;
        bus.mode_sel     = '0;
        bus.solid_rgb    = '0;
        bus.scroll_en    = 1'b0;
        bus.scroll_step  = '0;

        //  name           rst hs vs de hpos vpos mode solid sen step rgb
        add("rst0",          0, 1, 0, 1,   8,   3, 0, 0, 0, 0, 3'b000);
        add("rst_edge",      0, 0, 1, 1,   8,   3, 0, 0, 0, 0, 3'b000);
        add("grid_a",        1, 1, 0, 1,   8,   3, 0, 0, 0, 0, 3'b001);
        add("grid_b",        1, 0, 0, 1,  17,   1, 0, 0, 0, 0, 3'b100);
        add("grid_blank",    1, 0, 0, 0,   8,   3, 0, 0, 0, 0, 3'b000);
        add("midframe",      1, 0, 0, 1, 448,   5, 1, 0, 0, 0, 3'b001);
        add("edge_old",      1, 0, 1, 1, 448,   5, 1, 0, 0, 0, 3'b001);
        add("bars_448",      1, 1, 1, 1, 448,   5, 1, 0, 0, 0, 3'b111);
        add("bars_320",      1, 1, 0, 1, 320,   5, 1, 0, 0, 0, 3'b101);
        add("bars_64",       1, 0, 0, 1,  64,   5, 1, 0, 0, 0, 3'b001);
        add("to_chk",        1, 0, 0, 1,   0,   0, 2, 0, 0, 0, 3'b000);
        add("chk_edge",      1, 0, 1, 1,   8,   0, 2, 0, 0, 0, 3'b000);
        add("chk_a",         1, 0, 1, 1,   8,   0, 2, 0, 0, 0, 3'b111);
        add("chk_b",         1, 0, 0, 1,   8,   8, 2, 0, 0, 0, 3'b000);
        add("chk_c",         1, 0, 0, 1,   0,   8, 2, 0, 0, 0, 3'b111);
        add("ramp_edge",     1, 0, 1, 1,   0, 256, 3, 0, 0, 0, 3'b000);
        add("ramp_a",        1, 0, 1, 1, 256,   0, 3, 0, 0, 0, 3'b101);
        add("ramp_b",        1, 0, 0, 1,   0, 256, 3, 0, 0, 0, 3'b110);
        add("solid_edge",    1, 0, 1, 1,   0,   0, 4, 6, 0, 0, 3'b100);
        add("solid_a",       1, 0, 1, 1,   0,   0, 4, 1, 0, 0, 3'b110);
        add("solid_blank",   1, 0, 0, 0,   0,   0, 4, 1, 0, 0, 3'b000);
        add("mode5_edge",    1, 0, 1, 1,   0,   0, 5, 1, 0, 0, 3'b110);
        add("mode5",         1, 0, 0, 1,   8,   0, 5, 1, 0, 0, 3'b000);
        add("solid7_edge",   1, 0, 1, 1,   0,   0, 4, 7, 0, 0, 3'b000);
        add("solid7_blank",  1, 0, 0, 0,   0,   0, 4, 7, 0, 0, 3'b000);
        add("solid7",        1, 0, 0, 1,   0,   0, 4, 7, 0, 0, 3'b111);
        add("scr_e1",        1, 0, 1, 0,   0,   0, 1, 0, 1, 4, 3'b000);
        add("scr_l1",        1, 0, 0, 0,   0,   0, 1, 0, 1, 4, 3'b000);
        add("scr_e2",        1, 0, 1, 0,   0,   0, 1, 0, 1, 4, 3'b000);
        add("scr_l2",        1, 0, 0, 0,   0,   0, 1, 0, 1, 4, 3'b000);
        add("scr_e3",        1, 0, 1, 0,   0,   0, 1, 0, 1, 4, 3'b000);
        add("scroll_500",    1, 0, 0, 1, 500,   0, 1, 0, 0, 0, EXP_SCR_500);
        add("scroll_308",    1, 0, 0, 1, 308,   0, 1, 0, 0, 0, EXP_SCR_308);
        add("rst_mid",       0, 0, 1, 1, 448,   5, 1, 0, 0, 0, 3'b000);
        add("rst_release",   1, 0, 0, 1, 448,   5, 1, 0, 0, 0, 3'b001);

        foreach (vecs[i]) apply(vecs[i]);

        // Frame counter wraps back to zero after 256 frame edges.
        for (int n = 0; n < 256; n++) begin
            v = '{name: "wrap_hi", rst_n: 1'b1, hs: 1'b0, vs: 1'b1, de: 1'b0,
                  hpos: 9'd0, vpos: 9'd0, mode: 3'd0, solid: 3'd0, sen: 1'b0,
                  step: 4'd0, rgb: 3'b000};
            apply(v);
            v.name = "wrap_lo";
            v.vs   = 1'b0;
            apply(v);
        end
        v = '{name: "wrap_done", rst_n: 1'b1, hs: 1'b0, vs: 1'b0, de: 1'b1,
              hpos: 9'd8, vpos: 9'd3, mode: 3'd0, solid: 3'd0, sen: 1'b0,
              step: 4'd0, rgb: 3'b001};
        apply(v);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
